// File: rtl/display_scan_driver.sv
// display_scan_driver
//
// Time-multiplexed driver for a 4-digit common-anode seven-segment display
// that shows the mm.ss timer. Each digit slot opens with one dark guard
// cycle so the previous digit cannot ghost. After that the slot drives the
// current digit from a snapshot. The snapshot is taken once per frame, so a
// frame never mixes two counter states. Leading-zero blanking and PWM
// brightness apply on top.
//
// Optional feature macro: DISPLAY_FLASH_EN
//   defined   -> the flash counter and flash_on toggle are built in. Digits
//                selected by FLASH_MASK go dark for FLASH_FRAMES frames, then
//                light for FLASH_FRAMES frames.
//   undefined -> no flash logic. FLASH_MASK, FLASH_FRAMES and FLASH_W are
//                ignored.
//
// Parameters:
//   FLASH_FRAMES : scan frames per flash half-period
//   FLASH_W      : flash frame counter width (2**FLASH_W > FLASH_FRAMES)
//
// Ports:
//   CLK          in   system clock
//   RESET        in   asynchronous active-low reset
//   SCAN_TICK    in   one-cycle pulse, advances the scan by one digit
//   DIGIT0..3    in   [4] dot, [3:0] hex value; DIGIT0 is the rightmost digit
//   BLANK_LZ     in   leading-zero blanking enable
//   BRIGHT       in   duty control, anode on while pwm <= BRIGHT
//   FLASH_MASK   in   bit n makes digit n flash
//   SEG_SELECT   out  active-low anode selects, bit n drives digit n
//   DEC_OUT      out  active-low cathodes, [0]=a .. [6]=g, [7]=dp
//   FRAME_DONE   out  one-cycle pulse when the scan wraps from digit 3 to 0

module display_scan_driver #(
    parameter int FLASH_FRAMES = 625,
    parameter int FLASH_W      = 10
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       SCAN_TICK,
    input  logic [4:0] DIGIT0,
    input  logic [4:0] DIGIT1,
    input  logic [4:0] DIGIT2,
    input  logic [4:0] DIGIT3,
    input  logic       BLANK_LZ,
    input  logic [2:0] BRIGHT,
    input  logic [3:0] FLASH_MASK,
    output logic [3:0] SEG_SELECT,
    output logic [7:0] DEC_OUT,
    output logic       FRAME_DONE
);

    localparam logic [0:0] ST_DRIVE = 1'b0;
    localparam logic [0:0] ST_GUARD = 1'b1;

    logic [0:0] state;
    logic [0:0] state_next;
    logic [1:0] idx;
    logic [4:0] snap0, snap1, snap2, snap3;
    logic [2:0] pwm;
    logic       wrap;
    logic       blank1, blank2, blank3;
    logic [4:0] cur;
    logic       cur_blank;
    logic       dark;
    logic [6:0] seg_on;

    assign wrap = SCAN_TICK && (idx == 2'd3);

    // A tick always opens (or re-opens) the guard cycle, even mid-guard,
    // so ticks arriving back to back are never lost.
    always_comb begin
        state_next = state;
        case (state)
            ST_GUARD: state_next = SCAN_TICK ? ST_GUARD : ST_DRIVE;
            default:  state_next = SCAN_TICK ? ST_GUARD : ST_DRIVE;
        endcase
    end

    // Scan index, frame snapshot, FSM state and the free-running PWM phase.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= ST_DRIVE;
            idx   <= 2'd0;
            snap0 <= 5'd0;
            snap1 <= 5'd0;
            snap2 <= 5'd0;
            snap3 <= 5'd0;
            pwm   <= 3'd0;
        end else begin
            state <= state_next;
            pwm   <= pwm + 3'd1;
            if (SCAN_TICK) begin
                idx <= idx + 2'd1;
            end
            if (wrap) begin
                snap0 <= DIGIT0;
                snap1 <= DIGIT1;
                snap2 <= DIGIT2;
                snap3 <= DIGIT3;
            end
        end
    end

    // Blanking cascades down from the leftmost digit. A set dot stops it.
    assign blank3 = BLANK_LZ && (snap3 == 5'd0);
    assign blank2 = blank3 && (snap2 == 5'd0);
    assign blank1 = blank2 && (snap1 == 5'd0);

    always_comb begin
        cur       = snap0;
        cur_blank = 1'b0;
        case (idx)
            2'd1: begin cur = snap1; cur_blank = blank1; end
            2'd2: begin cur = snap2; cur_blank = blank2; end
            2'd3: begin cur = snap3; cur_blank = blank3; end
            default: begin cur = snap0; cur_blank = 1'b0; end
        endcase
    end

    // Active-high segment pattern {g,f,e,d,c,b,a}. A-F are shown as A b C d E F.
    always_comb begin
        seg_on = 7'h00;
        case (cur[3:0])
            4'h0: seg_on = 7'h3F;
            4'h1: seg_on = 7'h06;
            4'h2: seg_on = 7'h5B;
            4'h3: seg_on = 7'h4F;
            4'h4: seg_on = 7'h66;
            4'h5: seg_on = 7'h6D;
            4'h6: seg_on = 7'h7D;
            4'h7: seg_on = 7'h07;
            4'h8: seg_on = 7'h7F;
            4'h9: seg_on = 7'h6F;
            4'hA: seg_on = 7'h77;
            4'hB: seg_on = 7'h7C;
            4'hC: seg_on = 7'h39;
            4'hD: seg_on = 7'h5E;
            4'hE: seg_on = 7'h79;
            default: seg_on = 7'h71;
        endcase
    end

`ifdef DISPLAY_FLASH_EN
    logic [FLASH_W-1:0] flash_cnt;
    logic               flash_on;

    // Counts completed frames and flips visibility every FLASH_FRAMES frames.
    // It updates on the wrap edge, so the new phase starts with digit 0.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            flash_cnt <= '0;
            flash_on  <= 1'b1;
        end else if (wrap) begin
            if (flash_cnt == FLASH_W'(FLASH_FRAMES - 1)) begin
                flash_cnt <= '0;
                flash_on  <= ~flash_on;
            end else begin
                flash_cnt <= flash_cnt + 1'b1;
            end
        end
    end

    assign dark = ~flash_on & FLASH_MASK[idx];
`else
    localparam int unused_flash_cfg = FLASH_FRAMES + FLASH_W;
    logic unused_flash_mask;
    assign unused_flash_mask = ^FLASH_MASK;
    assign dark = 1'b0;
`endif

    // Registered outputs. A guard cycle is fully dark.
    // A blank or flashed-off digit keeps its anode (subject to PWM) but lights
    // no cathodes.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            SEG_SELECT <= 4'hF;
            DEC_OUT    <= 8'hFF;
            FRAME_DONE <= 1'b0;
        end else begin
            FRAME_DONE <= wrap;
            if (state_next == ST_GUARD) begin
                SEG_SELECT <= 4'hF;
                DEC_OUT    <= 8'hFF;
            end else begin
                SEG_SELECT <= (pwm <= BRIGHT) ? ~(4'b0001 << idx) : 4'hF;
                DEC_OUT    <= (cur_blank || dark) ? 8'hFF : ~{cur[4], seg_on};
            end
        end
    end

endmodule

// File: tb/tb_display_scan_driver.sv
// tb_display_scan_driver
//
// Bench for display_scan_driver. A behavioural model derives SEG_SELECT,
// DEC_OUT and FRAME_DONE from the display rules. The rules cover digit
// slots, frame snapshots, blanking as "all digits from here leftwards are
// zero", PWM duty from cycles since reset, and flash phase from completed
// frames. The model is compared against the DUT on every cycle. Directed
// literal checks pin the model at known points.

module tb_display_scan_driver;

    localparam int FLASH_N = 3;

    logic       CLK;
    logic       RESET;
    logic       SCAN_TICK;
    logic [4:0] DIGIT0, DIGIT1, DIGIT2, DIGIT3;
    logic       BLANK_LZ;
    logic [2:0] BRIGHT;
    logic [3:0] FLASH_MASK;
    logic [3:0] SEG_SELECT;
    logic [7:0] DEC_OUT;
    logic       FRAME_DONE;

    int compared   = 0;
    int mismatched = 0;
    bit checking   = 1'b0;

    display_scan_driver #(
        .FLASH_FRAMES(FLASH_N),
        .FLASH_W     (2)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .SCAN_TICK (SCAN_TICK),
        .DIGIT0    (DIGIT0),
        .DIGIT1    (DIGIT1),
        .DIGIT2    (DIGIT2),
        .DIGIT3    (DIGIT3),
        .BLANK_LZ  (BLANK_LZ),
        .BRIGHT    (BRIGHT),
        .FLASH_MASK(FLASH_MASK),
        .SEG_SELECT(SEG_SELECT),
        .DEC_OUT   (DEC_OUT),
        .FRAME_DONE(FRAME_DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Active-high {g..a} patterns of the hex glyphs.
    logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model state: digit slot, frame snapshot, cycles and frames since reset.
    int         m_idx;
    logic [4:0] m_snap [4];
    int         m_cyc;
    int         m_frames;
    logic [3:0] exp_seg = 4'hF;
    logic [7:0] exp_dec = 8'hFF;
    logic       exp_fd  = 1'b0;

    // Each rising edge decides what the display shows for the following cycle.
    always @(posedge CLK or negedge RESET) begin
        int   pwm_phase;
        int   slot;
        bit   blank;
        bit   dark;
        if (!RESET) begin
            m_idx    <= 0;
            m_cyc    <= 0;
            m_frames <= 0;
            for (int k = 0; k < 4; k++) m_snap[k] <= 5'd0;
            exp_seg  <= 4'hF;
            exp_dec  <= 8'hFF;
            exp_fd   <= 1'b0;
        end else begin
            pwm_phase = m_cyc % 8;
            m_cyc    <= m_cyc + 1;
            if (SCAN_TICK) begin
                m_idx   <= (m_idx + 1) % 4;
                exp_fd  <= (m_idx == 3);
                exp_seg <= 4'hF;
                exp_dec <= 8'hFF;
                if (m_idx == 3) begin
                    m_snap[0] <= DIGIT0;
                    m_snap[1] <= DIGIT1;
                    m_snap[2] <= DIGIT2;
                    m_snap[3] <= DIGIT3;
                    m_frames  <= m_frames + 1;
                end
            end else begin
                slot  = m_idx;
                blank = 1'b0;
                if (BLANK_LZ && slot > 0) begin
                    blank = 1'b1;
                    for (int k = slot; k < 4; k++)
                        if (m_snap[k] != 5'd0) blank = 1'b0;
                end
                dark = 1'b0;
`ifdef DISPLAY_FLASH_EN
                dark = FLASH_MASK[slot] && (((m_frames / FLASH_N) % 2) == 1);
`endif
                exp_fd  <= 1'b0;
                exp_dec <= (blank || dark) ? 8'hFF
                                           : ~{m_snap[slot][4], glyph_tab[m_snap[slot][3:0]]};
                exp_seg <= (pwm_phase <= int'(BRIGHT)) ? ~(4'b0001 << slot) : 4'hF;
            end
        end
    end

    task automatic compareVal(input string name, input logic [7:0] actual,
                              input logic [7:0] required);
        compared++;
        if (actual !== required) begin
            mismatched++;
            $display("[TB] FAIL %s: actual %h required %h at %0t", name, actual, required, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        if (checking) begin
            compareVal("model_seg", {4'h0, SEG_SELECT}, {4'h0, exp_seg});
            compareVal("model_dec", DEC_OUT, exp_dec);
            compareVal("model_fd",  {7'h0, FRAME_DONE}, {7'h0, exp_fd});
        end
    end

    task automatic checkOutput(input string name, input logic [3:0] seg,
                               input logic [7:0] dec, input logic fd);
        compareVal({name, "_seg"}, {4'h0, SEG_SELECT}, {4'h0, seg});
        compareVal({name, "_dec"}, DEC_OUT, dec);
        compareVal({name, "_fd"},  {7'h0, FRAME_DONE}, {7'h0, fd});
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Ends on the falling edge inside the guard cycle that follows the tick.
    task automatic tickOnce();
        @(negedge CLK);
        SCAN_TICK = 1'b1;
        @(negedge CLK);
        SCAN_TICK = 1'b0;
    endtask

    task automatic applyStimulus(input int ticks, input int gap);
        for (int i = 0; i < ticks; i++) begin
            tickOnce();
            idle(gap);
        end
    endtask

    // One slot: tick, then check the first driven cycle.
    task automatic slotCheck(input string name, input logic [3:0] seg,
                             input logic [7:0] dec, input int gap);
        tickOnce();
        @(negedge CLK);
        checkOutput(name, seg, dec, 1'b0);
        idle(gap);
    endtask

    task automatic dutyCount(input string name, input int required);
        int lit = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            if (SEG_SELECT != 4'hF) lit++;
        end
        compareVal(name, 8'(lit), 8'(required));
    endtask

    initial begin
        RESET      = 1'b1;
        SCAN_TICK  = 1'b0;
        DIGIT3     = 5'h01;
        DIGIT2     = 5'h12;
        DIGIT1     = 5'h05;
        DIGIT0     = 5'h09;
        BRIGHT     = 3'd7;
        BLANK_LZ   = 1'b0;
        FLASH_MASK = 4'b0000;
        #1;
        RESET    = 1'b0;
        checking = 1'b1;

        // Reset and first frame.
        idle(3);
        checkOutput("reset", 4'hF, 8'hFF, 1'b0);
        RESET = 1'b1;
        idle(1);
        checkOutput("post_reset_d0", 4'b1110, 8'hC0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tickOnce();
            idle(99);
        end
        tickOnce();
        checkOutput("wrap_guard", 4'hF, 8'hFF, 1'b1);
        @(negedge CLK);
        checkOutput("f1_d0", 4'b1110, 8'h90, 1'b0);
        idle(98);
        slotCheck("f1_d1", 4'b1101, 8'h92, 20);
        slotCheck("f1_d2", 4'b1011, 8'h24, 20);

        // Snapshot coherence: changes mid-frame wait for the next wrap.
        DIGIT0 = 5'h03;
        slotCheck("f1_d3", 4'b0111, 8'hF9, 20);
        slotCheck("f2_d0", 4'b1110, 8'hB0, 20);
        DIGIT1 = 5'h0A;
        slotCheck("f2_d1_old", 4'b1101, 8'h92, 20);
        slotCheck("f2_d2", 4'b1011, 8'h24, 20);
        slotCheck("f2_d3", 4'b0111, 8'hF9, 20);

        // Leading-zero blanking.
        BLANK_LZ = 1'b1;
        DIGIT3 = 5'h00; DIGIT2 = 5'h00; DIGIT1 = 5'h00; DIGIT0 = 5'h07;
        slotCheck("lz1_d0", 4'b1110, 8'hF8, 20);
        slotCheck("lz1_d1", 4'b1101, 8'hFF, 20);
        slotCheck("lz1_d2", 4'b1011, 8'hFF, 20);
        DIGIT2 = 5'h10;
        slotCheck("lz1_d3", 4'b0111, 8'hFF, 20);
        slotCheck("lz2_d0", 4'b1110, 8'hF8, 20);
        slotCheck("lz2_d1", 4'b1101, 8'hC0, 20);
        slotCheck("lz2_d2", 4'b1011, 8'h40, 20);
        slotCheck("lz2_d3", 4'b0111, 8'hFF, 20);

        // Brightness: duty over 16 driven cycles.
        BRIGHT = 3'd1;
        dutyCount("duty_bright1", 4);
        BRIGHT = 3'd0;
        dutyCount("duty_bright0", 2);
        BRIGHT = 3'd7;
        idle(2);

        // Two ticks back to back from slot 3: wrap, then slot 1.
        BLANK_LZ = 1'b0;
        @(negedge CLK);
        SCAN_TICK = 1'b1;
        @(negedge CLK);
        checkOutput("dbl_guard1", 4'hF, 8'hFF, 1'b1);
        @(negedge CLK);
        SCAN_TICK = 1'b0;
        checkOutput("dbl_guard2", 4'hF, 8'hFF, 1'b0);
        @(negedge CLK);
        checkOutput("dbl_d1", 4'b1101, 8'hC0, 1'b0);
        idle(5);

        // Asynchronous reset mid-frame.
        @(posedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        checkOutput("async_rst", 4'hF, 8'hFF, 1'b0);
        @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        checkOutput("rst_d0", 4'b1110, 8'hC0, 1'b0);
        slotCheck("rst_d1", 4'b1101, 8'hC0, 10);

        // Flash behaviour (mask ignored unless the feature is built in).
        DIGIT3 = 5'h01; DIGIT2 = 5'h02; DIGIT1 = 5'h03; DIGIT0 = 5'h04;
        FLASH_MASK = 4'b0011;
        applyStimulus(32, 10);

        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
